// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: XLEN, bubble instruction, reset PC and
// the fetch-stage FSM encoding.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        IF_RUN     = 1'b0,
        IF_WAIT_BR = 1'b1
    } if_state_e;

    // Redirect targets are always word aligned; low bits are discarded.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Program counter register with redirect / hold / increment next-PC select.
// Redirect has priority over hold; PC arithmetic wraps modulo 2^32.
module if_pc_gen
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_hold,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_target,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc_q;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc_q + 32'd4;
        if (i_redirect) begin
            w_pc_next = align_word(i_target);
        end else if (i_hold) begin
            w_pc_next = r_pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc_q <= RESET_PC;
        end else begin
            r_pc_q <= w_pc_next;
        end
    end

    assign o_pc = r_pc_q;

endmodule

// File: rtl/if_stage.sv
// RV32I instruction fetch stage: FSM, IF/ID pipeline register and PC generator.
// Define IF_PERF_CNT_EN to add the saturating bubble_cnt output.
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_id_cstall,
    input  logic            hz_stall,
    input  logic            br_resolved,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic            id_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] bubble_cnt
`endif
);

    if_state_e       r_state;
    if_state_e       w_state_next;
    logic            w_pc_hold;
    logic            w_redirect;
    logic            w_load_fetch;
    logic            w_load_bubble;
    logic [XLEN-1:0] w_pc;

    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_instr;
    logic            r_id_valid;

    if_pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hold     (w_pc_hold),
        .i_redirect (w_redirect),
        .i_target   (br_target),
        .o_pc       (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IF_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_hold     = 1'b1;
        w_redirect    = 1'b0;
        w_load_fetch  = 1'b0;
        w_load_bubble = 1'b0;
        case (r_state)
            IF_RUN: begin
                if (br_resolved && br_taken) begin
                    w_redirect    = 1'b1;
                    w_load_bubble = 1'b1;
                end else if (hz_stall) begin
                    // Load-use freeze: PC and IF/ID keep their values.
                    w_pc_hold = 1'b1;
                end else if (if_id_cstall) begin
                    w_load_bubble = 1'b1;
                    w_state_next  = IF_WAIT_BR;
                end else begin
                    w_pc_hold    = 1'b0;
                    w_load_fetch = 1'b1;
                end
            end
            IF_WAIT_BR: begin
                // pc_q already holds the fall-through, so not-taken just resumes.
                w_load_bubble = 1'b1;
                if (br_resolved) begin
                    w_redirect   = br_taken;
                    w_state_next = IF_RUN;
                end
            end
            default: begin
                w_state_next = IF_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_id_pc    <= '0;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (w_load_bubble) begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (w_load_fetch) begin
            r_id_pc    <= w_pc;
            r_id_instr <= imem_rdata;
            r_id_valid <= 1'b1;
        end
    end

    assign imem_addr = w_pc;
    assign id_pc     = r_id_pc;
    assign id_instr  = r_id_instr;
    assign id_valid  = r_id_valid;

`ifdef IF_PERF_CNT_EN
    logic [XLEN-1:0] r_bubble_cnt;

    function automatic logic [XLEN-1:0] sat_inc(input logic [XLEN-1:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (w_load_bubble) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage with integrated IF/ID pipeline register for the RV32I 5-stage core. Generates the PC, drives the instruction-memory address, and latches {pc, instruction, valid} into IF/ID. Consumes `if_id_cstall` from the control-stall unit and `hz_stall` from the hazard unit. Inserts bubbles while a decoded branch is unresolved, then redirects to the target or the fall-through.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, `addi x0,x0,0` placed in IF/ID for bubbles.
- `clk`  input  1  core clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `if_id_cstall`  input  1  control stall: a branch or jump is in ID.
- `hz_stall`  input  1  load-use stall; freeze PC and IF/ID.
- `br_resolved`  input  1  branch/jump in EX resolved this cycle.
- `br_taken`  input  1  qualifies `br_target`, valid with `br_resolved`.
- `br_target`  input  32  redirect address, valid with `br_resolved`.
- `imem_addr`  output  32  equals current PC (combinational from `pc_q`).
- `imem_rdata`  input  32  instruction at `imem_addr`, same-cycle (asynchronous ROM).
- `id_pc`  output  32  registered PC of the instruction in ID.
- `id_instr`  output  32  registered instruction in ID.
- `id_valid`  output  1  ID holds a real instruction; 0 = bubble.

## Operation
- FSM states: RUN, WAIT_BR. Reset state is RUN.
- RUN, evaluated in priority order:
  - `br_resolved & br_taken`: redirect (see below) and load a bubble into IF/ID.
  - `hz_stall`: hold `pc_q` and IF/ID unchanged. `if_id_cstall` is ignored this cycle and re-evaluated next cycle.
  - `if_id_cstall`: hold `pc_q`, load a bubble into IF/ID (`id_instr`=`NOP_INSTR`, `id_valid`=0, `id_pc` unchanged), go to WAIT_BR.
  - Otherwise: `pc_q <= pc_q + 4`, `id_pc <= pc_q`, `id_instr <= imem_rdata`, `id_valid <= 1`.
- WAIT_BR:
  - Hold `pc_q`, which holds the fall-through address (branch PC + 4).
  - Load a bubble into IF/ID every cycle.
  - `hz_stall` and `if_id_cstall` are ignored.
  - On `br_resolved`: if `br_taken`, `pc_q <= {br_target[31:2], 2'b00}`; else `pc_q` keeps the fall-through. Return to RUN.
- Redirect address bits [1:0] are always forced to 0. Misaligned-target exceptions are out of scope.
- PC arithmetic is 32-bit modular; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- `br_resolved` with `br_taken`=0 while in RUN is a no-op.

## Timing
- Reset (`rst_n`=0 at an edge) sets `pc_q`=`RESET_PC`, `id_pc`=0, `id_instr`=`NOP_INSTR`, `id_valid`=0, state RUN, and the bubble counter to 0.
- Reset overrides every other input, including in the middle of WAIT_BR.
- Fetch latency is 1 cycle: the instruction at `pc_q` in cycle t is in ID in cycle t+1.
- Branch penalty, with the branch in ID at cycle t (`if_id_cstall`=1):
  - ID holds a bubble at t+1 while the branch is in EX.
  - If `br_resolved` arrives at t+1, the target (or fall-through) is fetched at t+2 and is in ID at t+3.
  - Total: 2 bubbles. Each extra cycle before `br_resolved` adds one bubble.
- `imem_addr` changes only after clock edges and is never glitched by `br_*` inputs in the same cycle.

## Configuration
- `IF_PERF_CNT_EN` defined: adds output `bubble_cnt` (32 bits).
  - Increments once per edge on which a bubble is loaded into IF/ID because of control stall, WAIT_BR, or redirect.
  - Saturates at 32'hFFFF_FFFF. Cleared by reset.
  - `hz_stall` holds do not count.
- Undefined: the `bubble_cnt` port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `rv32i_pkg`: `NOP_INSTR` constant, `RESET_PC` default, FSM state encoding (`IF_RUN`, `IF_WAIT_BR`), XLEN=32.
- One sub-module, `if_pc_gen`: holds `pc_q` and computes next-PC from hold, increment, and redirect selects. `if_stage` owns the FSM, the IF/ID register, and the optional counter.

## Test plan
- Reset then 4 free-running cycles: `id_pc` sequence 0, 4, 8 with `id_valid`=1, and `imem_addr`=0x10 in cycle 4.
- Branch at 0x8, `if_id_cstall` at t, `br_resolved`/`br_taken`=1 with `br_target`=0x40 at t+1: bubbles at t+1 and t+2, `id_pc`=0x40 at t+3 (`bubble_cnt`=2 with `IF_PERF_CNT_EN`).
- Same branch, `br_taken`=0: after 2 bubbles `id_pc`=0xC. Target 0x43 with taken=1 fetches 0x40.
- `hz_stall` and `if_id_cstall` both high for 2 cycles: PC and IF/ID frozen, state stays RUN, `bubble_cnt` unchanged. Stall drops with cstall still high: enters WAIT_BR.
- `rst_n`=0 for 1 cycle in WAIT_BR: next cycle `pc_q`=`RESET_PC`, `id_valid`=0, state RUN, and a late `br_resolved` is ignored as a no-op.
- `pc_q`=0xFFFF_FFFC free-running: next `imem_addr`=0x0.
